// File: rtl/uart_tx_fifo.sv
// Transmit holding buffer in front of the UART transmitter: first-word fall-through
// FIFO with holding-register mode, flush, sticky overrun and low-watermark flag.
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_en,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic [1:0]       wm_level,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             wm_low,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovr;
    logic             en_q;

    logic          flush;
    logic          pop_eff;
    logic          push_ok;
    logic [CW-1:0] cap;
    logic [CW-1:0] wm_lvl;

    // Capacity follows the registered mode; a mode change flushes on the same edge
    // that updates en_q, so flags never see a stale capacity against live data.
    always_comb begin
        flush   = clr || (fifo_en != en_q);
        cap     = en_q ? CW'(DEPTH) : CW'(1);
        empty   = (cnt == '0);
        full    = (cnt == cap);
        pop_eff = pop && !empty;
        push_ok = push && (!full || pop_eff);
        count   = cnt;
        overrun = ovr;
        dout    = empty ? '0 : mem[rd_ptr];
    end

    always_comb begin
        wm_lvl = '0;
        case (wm_level)
            2'b00:   wm_lvl = CW'(0);
            2'b01:   wm_lvl = CW'(1);
            2'b10:   wm_lvl = CW'(DEPTH / 4);
            default: wm_lvl = CW'(DEPTH / 2);
        endcase
        wm_low = (cnt <= wm_lvl);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            en_q   <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            en_q   <= fifo_en;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_eff)
                cnt <= cnt + CW'(1);
            else if (pop_eff && !push_ok)
                cnt <= cnt - CW'(1);
            if (push && !push_ok)
                ovr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_en = 1'b1;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic [7:0] din = '0;
    logic       pop = 1'b0;
    logic [1:0] wm_level = 2'b00;
    logic [7:0] dout;
    logic       empty, full, wm_low, overrun;
    logic [4:0] count;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] m_q[$];
    bit         m_en = 1'b1;
    bit         m_ovr = 1'b0;

    uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .fifo_en(fifo_en), .clr(clr), .push(push), .din(din),
        .pop(pop), .wm_level(wm_level), .dout(dout), .empty(empty), .full(full),
        .count(count), .wm_low(wm_low), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] m_dout();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    function automatic bit m_wm();
        int lvl;
        case (wm_level)
            2'b00: lvl = 0;
            2'b01: lvl = 1;
            2'b10: lvl = 4;
            default: lvl = 8;
        endcase
        return m_q.size() <= lvl;
    endfunction

    // Apply one clock cycle of stimulus and advance the model with it.
    task automatic drive(input bit p, input bit pp, input logic [7:0] d, input bit c);
        int  cap;
        bit  pop_ok, push_ok;
        push = p; pop = pp; din = d; clr = c;
        @(posedge clk);
        cap = m_en ? 16 : 1;
        if (c || (fifo_en != m_en)) begin
            m_q.delete();
            m_ovr = 1'b0;
            m_en  = fifo_en;
        end else begin
            pop_ok  = pp && (m_q.size() > 0);
            push_ok = p && ((m_q.size() < cap) || pop_ok);
            if (pop_ok) void'(m_q.pop_front());
            if (push_ok) m_q.push_back(d);
            if (p && !push_ok) m_ovr = 1'b1;
        end
        #1;
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++;
        if ({empty, full, count, wm_low, overrun, dout} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL reset_values: got e=%b f=%b c=%0d wm=%b ov=%b d=%h, want e=1 f=0 c=0 wm=1 ov=0 d=00",
                     empty, full, count, wm_low, overrun, dout);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h41 + i), 0);
        tests++;
        if (full !== 1'b1 || count !== 5'd16) begin
            fails++;
            $display("FAIL fill_full: got full=%b count=%0d, want full=1 count=16", full, count);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (dout !== 8'(8'h41 + i)) begin
                fails++;
                $display("FAIL drain_order[%0d]: got %h, want %h", i, dout, 8'(8'h41 + i));
            end
            drive(0, 1, 0, 0);
        end
        tests++;
        if (empty !== 1'b1 || dout !== 8'h00) begin
            fails++;
            $display("FAIL drain_empty: got empty=%b dout=%h, want empty=1 dout=00", empty, dout);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'($urandom_range(0, 8'hA9)), 0);
        drive(1, 0, 8'hAA, 0);
        tests++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            fails++;
            $display("FAIL overrun_set: got overrun=%b count=%0d, want overrun=1 count=16", overrun, count);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (dout !== m_dout() || dout === 8'hAA) begin
                fails++;
                $display("FAIL overrun_drain[%0d]: got %h, want %h", i, dout, m_dout());
            end
            drive(0, 1, 0, 0);
        end
        drive(0, 0, 0, 1);
        tests++;
        if (overrun !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("FAIL clr_flush: got overrun=%b empty=%b, want overrun=0 empty=1", overrun, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) drive(1, 0, 8'($urandom_range(0, 255)), 0);
        drive(1, 1, 8'h55, 0);
        tests++;
        if (count !== 5'd16 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL full_push_pop: got count=%0d overrun=%b, want count=16 overrun=0", count, overrun);
        end
        for (int i = 0; i < 15; i++) drive(0, 1, 0, 0);
        tests++;
        if (dout !== 8'h55 || count !== 5'd1) begin
            fails++;
            $display("FAIL tail_byte: got dout=%h count=%0d, want dout=55 count=1", dout, count);
        end
        drive(0, 1, 0, 0);
        drive(1, 1, 8'h55, 0);
        tests++;
        if (count !== 5'd1 || dout !== 8'h55) begin
            fails++;
            $display("FAIL empty_push_pop: got count=%0d dout=%h, want count=1 dout=55", count, dout);
        end
        drive(0, 0, 0, 1);
    endtask

    task automatic test_holding();
        fifo_en = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 0, 8'h12, 0);
        tests++;
        if (full !== 1'b1 || count !== 5'd1) begin
            fails++;
            $display("FAIL hold_full: got full=%b count=%0d, want full=1 count=1", full, count);
        end
        drive(1, 0, 8'h34, 0);
        tests++;
        if (overrun !== 1'b1 || dout !== 8'h12) begin
            fails++;
            $display("FAIL hold_overrun: got overrun=%b dout=%h, want overrun=1 dout=12", overrun, dout);
        end
        fifo_en = 1'b1;
        drive(0, 0, 0, 0);
        tests++;
        if (count !== 5'd0 || overrun !== 1'b0 || full !== 1'b0) begin
            fails++;
            $display("FAIL mode_flush: got count=%0d overrun=%b full=%b, want 0 0 0", count, overrun, full);
        end
    endtask

    task automatic test_watermark();
        wm_level = 2'b10;
        for (int i = 0; i < 5; i++) drive(1, 0, 8'(i), 0);
        tests++;
        if (wm_low !== 1'b0) begin
            fails++;
            $display("FAIL wm_above: got wm_low=%b, want 0 (count=%0d)", wm_low, count);
        end
        drive(0, 1, 0, 0);
        tests++;
        if (wm_low !== 1'b1) begin
            fails++;
            $display("FAIL wm_at_level: got wm_low=%b, want 1 (count=%0d)", wm_low, count);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        wm_level = 2'b00;
        #1;
        tests++;
        if (wm_low !== 1'b0 || count !== 5'd1) begin
            fails++;
            $display("FAIL wm_zero: got wm_low=%b count=%0d, want wm_low=0 count=1", wm_low, count);
        end
        drive(0, 0, 0, 1);
    endtask

    // Transmitter stand-in: latches dout when it starts, pops one cycle later,
    // then stays busy for a 10-bit 8N1 frame of 4 cycles per bit.
    task automatic test_loopback();
        logic [7:0] got[$];
        int pops = 0;
        int budget = 0;
        drive(1, 0, 8'hC3, 0);
        drive(1, 0, 8'h3C, 0);
        while (budget < 400 && !(empty && got.size() == 2)) begin
            if (!empty) begin
                got.push_back(dout);
                drive(0, 0, 0, 0);
                drive(0, 1, 0, 0);
                pops++;
                for (int b = 0; b < 40; b++) drive(0, 0, 0, 0);
                budget += 42;
            end else begin
                drive(0, 0, 0, 0);
                budget++;
            end
        end
        tests++;
        if (got.size() != 2 || pops != 2 || empty !== 1'b1) begin
            fails++;
            $display("FAIL loopback_count: got frames=%0d pops=%0d empty=%b, want 2 2 1", got.size(), pops, empty);
        end else begin
            tests++;
            if (got[0] !== 8'hC3 || got[1] !== 8'h3C) begin
                fails++;
                $display("FAIL loopback_order: got %h %h, want c3 3c", got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wm_level = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 2) fifo_en = ~fifo_en;
            drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 2));
            tests++;
            if ({dout, empty, full, count, wm_low, overrun} !==
                {m_dout(), m_q.size() == 0, m_q.size() == (m_en ? 16 : 1), 5'(m_q.size()), m_wm(), m_ovr}) begin
                fails++;
                $display("FAIL random[%0d]: got d=%h e=%b f=%b c=%0d wm=%b ov=%b, want d=%h c=%0d wm=%b ov=%b",
                         i, dout, empty, full, count, wm_low, overrun, m_dout(), m_q.size(), m_wm(), m_ovr);
            end
        end
    endtask

    task automatic test_async_reset();
        fifo_en = 1'b1;
        drive(0, 0, 0, 1);
        drive(1, 0, 8'h77, 0);
        drive(1, 0, 8'h78, 0);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({empty, full, count, wm_low, overrun, dout} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL async_reset: got e=%b c=%0d ov=%b d=%h, want e=1 c=0 ov=0 d=00",
                     empty, count, overrun, dout);
        end
        m_q.delete(); m_ovr = 1'b0; m_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overrun();
        test_simultaneous();
        test_holding();
        test_watermark();
        test_loopback();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
